// File: rtl/normalize_round_pipe.sv
// Normalize-and-round back end of the MAC alignment path: leading-one detect, left-normalize,
// round-nearest-even to MAN_W bits and rebuild the exponent, over a 2-stage valid/ready pipeline.
module normalize_round_pipe #(
  parameter int SUM_W  = 16,
  parameter int LD_POS = 13,
  parameter int EXP_W  = 6,
  parameter int MAN_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic [EXP_W-1:0] max_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic [3:0]       out_flags,
  output logic [50:0]      number
);
  localparam int PW = $clog2(SUM_W);
  localparam int EW = EXP_W + 2;
  localparam int RW = 1 + EXP_W + MAN_W + 4;
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_MIN = EW'(1);
  localparam logic signed [EW-1:0] E_LD  = EW'(LD_POS);

  logic                    vld_p1, vld_p2, load_p2;
  logic                    sign_p1;
  logic [SUM_W-1:0]        mag_p1;
  logic [EXP_W-1:0]        exp_p1;
  logic signed [SUM_W-1:0] sum_s;
  logic [SUM_W-1:0]        mag_in;
  logic [PW-1:0]           p_msb;
  logic [SUM_W-1:0]        norm;
  logic [MAN_W+1:0]        rnd;
  logic signed [EW-1:0]    e_full;
  logic [RW-1:0]           res;

  // Highest set bit; later iterations override, so the MSB wins.
  function automatic logic [PW-1:0] msb_index(input logic [SUM_W-1:0] v);
    msb_index = '0;
    for (int i = 0; i < SUM_W; i++)
      if (v[i]) msb_index = PW'(i);
  endfunction

  // Returns {carry, inexact, man}; a carry out of 1..1 wraps the mantissa to 10..0.
  function automatic logic [MAN_W+1:0] round_ne(input logic [SUM_W-1:0] nv);
    logic [MAN_W-1:0] man;
    logic             guard, sticky, up;
    logic [MAN_W:0]   sum;
    man    = nv[SUM_W-1 -: MAN_W];
    guard  = nv[SUM_W-1-MAN_W];
    sticky = |nv[SUM_W-2-MAN_W:0];
    up     = guard & (sticky | man[0]);
    sum    = {1'b0, man} + {{MAN_W{1'b0}}, up};
    if (sum[MAN_W]) sum[MAN_W-1:0] = {1'b1, {(MAN_W-1){1'b0}}};
    round_ne = {sum[MAN_W], guard | sticky, sum[MAN_W-1:0]};
  endfunction

  // Range handling: saturate above E_MAX, flush to zero below E_MIN (no denormals).
  function automatic logic [RW-1:0] saturate(input logic sign, input logic signed [EW-1:0] e,
                                             input logic [MAN_W-1:0] man, input logic inexact);
    if (e > E_MAX)
      saturate = {sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}, 4'b1010};
    else if (e < E_MIN)
      saturate = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}, 4'b1100};
    else
      saturate = {sign, e[EXP_W-1:0], man, inexact, 3'b000};
  endfunction

  assign load_p2   = !vld_p2 || out_ready;
  assign in_ready  = !vld_p1 || load_p2;
  assign out_valid = vld_p2;
  // No primitive cells are instantiated, so the static cell total is zero.
  assign number    = '0;

  // Stage 1: sign split and magnitude; -2^(SUM_W-1) maps to its unsigned magnitude.
  assign sum_s  = in_sum;
  assign mag_in = (sum_s < 0) ? (~in_sum) + SUM_W'(1) : in_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      sign_p1 <= in_sum[SUM_W-1];
      mag_p1  <= mag_in;
      exp_p1  <= max_exp;
    end
  end

  // Stage 2: normalize, round, rebuild exponent, range check.
  always_comb begin
    p_msb  = msb_index(mag_p1);
    norm   = mag_p1 << (PW'(SUM_W - 1) - p_msb);
    rnd    = round_ne(norm);
    e_full = $signed({2'b00, exp_p1}) + $signed({{(EW-PW){1'b0}}, p_msb}) - E_LD
           + $signed({{(EW-1){1'b0}}, rnd[MAN_W+1]});
    if (mag_p1 == '0)
      res = {1'b0, {EXP_W{1'b0}}, {MAN_W{1'b0}}, 4'b0001};
    else
      res = saturate(sign_p1, e_full, rnd[MAN_W-1:0], rnd[MAN_W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_man   <= '0;
      out_flags <= '0;
    end else if (load_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) {out_sign, out_exp, out_man, out_flags} <= res;
    end
  end
endmodule

// File: tb/tb_normalize_round_pipe.sv
// Bench for normalize_round_pipe: directed spec vectors, stall/ordering, mid-stream reset,
// and randomized traffic with backpressure against an integer-arithmetic reference model.
module tb_normalize_round_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sum;
  logic [5:0]  max_exp;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [5:0]  out_exp;
  logic [2:0]  out_man;
  logic [3:0]  out_flags;
  logic [50:0] number;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [13:0] got_q[$];
  int          got_cyc[$];
  logic [13:0] exp_q[$];

  normalize_round_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .max_exp(max_exp), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_man(out_man), .out_flags(out_flags),
    .number(number)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // A transfer happens at the next posedge when valid & ready are seen here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back({out_sign, out_exp, out_man, out_flags});
      got_cyc.push_back(cycle);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: {sign, exp, man, flags{inexact,underflow,overflow,zero}} from plain integer math.
  function automatic logic [13:0] model(input logic [15:0] s, input int me);
    int  v, mag, p, man, rem, half, carry, e;
    bit  sign, inexact;
    v = int'($signed(s));
    if (v == 0) return 14'b0_000000_000_0001;
    sign = (v < 0);
    mag  = sign ? -v : v;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    if (p >= 2) begin
      man  = mag >> (p - 2);
      rem  = mag - (man << (p - 2));
      half = (p >= 3) ? (1 << (p - 3)) : 0;
    end else begin
      man  = mag << (2 - p);
      rem  = 0;
      half = 0;
    end
    inexact = (rem != 0);
    if (rem != 0 && (rem > half || (rem == half && (man % 2) == 1))) man++;
    carry = 0;
    if (man == 8) begin
      man   = 4;
      carry = 1;
    end
    e = me + p - 13 + carry;
    if (e > 63) return {sign, 6'h3f, 3'b111, 4'b1010};
    if (e < 1)  return {sign, 6'd0, 3'd0, 4'b1100};
    return {sign, 6'(e), 3'(man), inexact, 3'b000};
  endfunction

  task automatic send(input logic [15:0] s, input logic [5:0] e);
    int n = 0;
    in_valid = 1'b1;
    in_sum   = s;
    max_exp  = e;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 500) begin
        $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
        $fatal(1, "send timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_count(input int n, output bit ok);
    int k = 0;
    ok = 1'b1;
    while (got_q.size() < n) begin
      @(negedge clk);
      k++;
      if (k > 2000) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; max_exp = '0; out_ready = 1'b1;
    #3;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    checks++;
    if ({out_sign, out_exp, out_man, out_flags} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", {out_sign, out_exp, out_man, out_flags});
    end
    checks++;
    if (number !== 51'd0) begin
      errors++;
      $display("FAIL number: got %0d, required 0", number);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [15:0] s_tab[12] = '{16'h2000, 16'hE000, 16'h8000, 16'h3C00, 16'h3400, 16'h0000,
                               16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h2000};
    logic [5:0]  e_tab[12] = '{6'd10, 6'd10, 6'd10, 6'd10, 6'd10, 6'd10,
                               6'd2, 6'd63, 6'd63, 6'd14, 6'd12, 6'd63};
    logic [13:0] r_tab[12] = '{{1'b0, 6'd10, 3'b100, 4'b0000}, {1'b1, 6'd10, 3'b100, 4'b0000},
                               {1'b1, 6'd12, 3'b100, 4'b0000}, {1'b0, 6'd11, 3'b100, 4'b1000},
                               {1'b0, 6'd10, 3'b110, 4'b1000}, {1'b0, 6'd0, 3'b000, 4'b0001},
                               {1'b0, 6'd0, 3'b000, 4'b1100}, {1'b0, 6'd63, 3'b111, 4'b1010},
                               {1'b1, 6'd63, 3'b111, 4'b1010}, {1'b1, 6'd1, 3'b100, 4'b0000},
                               {1'b0, 6'd0, 3'b000, 4'b1100}, {1'b0, 6'd63, 3'b100, 4'b0000}};
    bit ok;
    logic [13:0] g;
    got_q.delete(); got_cyc.delete();
    for (int i = 0; i < 12; i++) send(s_tab[i], e_tab[i]);
    wait_count(12, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL directed_count: got %0d results, required 12", got_q.size());
    end
    for (int i = 0; i < 12 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      checks++;
      if (g !== r_tab[i]) begin
        errors++;
        $display("FAIL directed_%0d: in_sum=%h max_exp=%0d got %b required %b",
                 i, s_tab[i], e_tab[i], g, r_tab[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] ra = {1'b0, 6'd10, 3'b100, 4'b0000};
    logic [13:0] r_tab[4] = '{{1'b0, 6'd10, 3'b100, 4'b0000}, {1'b1, 6'd10, 3'b100, 4'b0000},
                              {1'b0, 6'd10, 3'b110, 4'b1000}, {1'b0, 6'd63, 3'b111, 4'b1010}};
    bit ok;
    logic [13:0] g;
    int c;
    @(posedge clk); #1;
    got_q.delete(); got_cyc.delete();
    out_ready = 1'b0;
    send(16'h2000, 6'd10);
    send(16'hE000, 6'd10);
    in_valid = 1'b1; in_sum = 16'h3400; max_exp = 6'd10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready: got %b, required 0 (cycle %0d)", in_ready, k);
      end
      checks++;
      if (out_valid !== 1'b1 || {out_sign, out_exp, out_man, out_flags} !== ra) begin
        errors++;
        $display("FAIL stall_hold: valid=%b out=%b, required 1 %b", out_valid,
                 {out_sign, out_exp, out_man, out_flags}, ra);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'h3400, 6'd10);
    send(16'h7FFF, 6'd63);
    wait_count(4, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, required 4", got_q.size());
    end
    c = (got_cyc.size() > 0) ? got_cyc[0] : 0;
    for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      checks++;
      if (g !== r_tab[i]) begin
        errors++;
        $display("FAIL b2b_order_%0d: got %b required %b", i, g, r_tab[i]);
      end
      checks++;
      if (got_cyc[i] !== c + i) begin
        errors++;
        $display("FAIL b2b_rate_%0d: emitted at cycle %0d, required %0d", i, got_cyc[i], c + i);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int seen;
    @(posedge clk); #1;
    got_q.delete(); got_cyc.delete();
    out_ready = 1'b1;
    send(16'h2000, 6'd20);
    send(16'h3C00, 6'd20);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || {out_sign, out_exp, out_man, out_flags} !== 14'd0) begin
      errors++;
      $display("FAIL midreset_outputs: valid=%b out=%h, required 0 0", out_valid,
               {out_sign, out_exp, out_man, out_flags});
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_dropped: out_valid cycles %0d results %0d, required 0 0",
               seen, got_q.size());
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [13:0] g, x;
    bit done = 1'b0;
    @(posedge clk); #1;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    fork
      begin
        logic [15:0] s;
        logic [5:0]  e;
        for (int i = 0; i < 80; i++) begin
          case ($urandom_range(0, 4))
            0:       s = 16'($urandom);
            1:       s = 16'($urandom_range(0, 63));
            2:       s = 16'(1 << $urandom_range(0, 15));
            3:       s = -16'($urandom_range(0, 300));
            default: s = 16'h8000 | 16'($urandom_range(0, 7));
          endcase
          e = 6'($urandom_range(0, 63));
          exp_q.push_back(model(s, int'(e)));
          send(s, e);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_count(80, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL random_count: got %0d results, required 80", got_q.size());
    end
    for (int i = 0; i < 80 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      x = exp_q.pop_front();
      checks++;
      if (g !== x) begin
        errors++;
        $display("FAIL random_%0d: got %b required %b", i, g, x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
